// File: rtl/ifmap_row_loader_pkg.sv
`default_nettype none
// ============================================================================
// Package     : ifmap_pkg
// Description : Shared constants and types for the ifmap row loader. It holds
//               the array geometry, the SRAM word width, the derived
//               words-per-row count, the loader FSM state type and the row and
//               word data types.
// Revision    : 1.0 - initial release
// ============================================================================
package ifmap_pkg;

    localparam int COL_NUM = 32;                    // array columns = bytes per row
    localparam int SRAM_DW = 32;                    // SRAM read-data width
    localparam int ADDR_W  = 16;                    // SRAM word-address width
    localparam int ROW_W   = COL_NUM * 8;           // bits per array row
    localparam int WPR     = ROW_W / SRAM_DW;       // SRAM words per row

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    typedef logic [ROW_W-1:0]   row_t;
    typedef logic [SRAM_DW-1:0] word_t;

endpackage : ifmap_pkg
`default_nettype wire

// File: rtl/ifmap_row_loader_if.sv
`default_nettype none
// ============================================================================
// Interface   : ifmap_row_loader_if
// Description : Data-path bundle of the ifmap row loader. It carries the SRAM
//               read port (sram_ren, sram_addr, sram_rdata) and the row output
//               (ifmap_out, ifmap_en) that feeds the vertical ifmap buffer.
//               The master modport is the loader side. The slave modport is
//               the SRAM / vertical-buffer side.
// Revision    : 1.0 - initial release
// ============================================================================
interface ifmap_row_loader_if;
    import ifmap_pkg::*;

    logic              sram_ren;
    logic [ADDR_W-1:0] sram_addr;
    word_t             sram_rdata;
    row_t              ifmap_out;
    logic              ifmap_en;

    modport master (
        output sram_ren,
        output sram_addr,
        input  sram_rdata,
        output ifmap_out,
        output ifmap_en
    );

    modport slave (
        input  sram_ren,
        input  sram_addr,
        output sram_rdata,
        input  ifmap_out,
        input  ifmap_en
    );

endinterface : ifmap_row_loader_if
`default_nettype wire

// File: rtl/ifmap_row_buf.sv
`default_nettype none
// ============================================================================
// Module      : ifmap_row_buf
// Description : Ping-pong pair of row buffers. Returned SRAM words are written
//               into the fill buffer at an internal word index. The word at
//               index WPR-1 completes the row: the buffer's full flag is set
//               and fill moves to the other buffer. The drain side offers the
//               oldest complete row. A row that completes in the same cycle as
//               it would be drained is forwarded directly.
// Ports       : clk, reset (async, active low)
//               wr_en, wr_word  - write port (one returned SRAM word)
//               pop             - drain the offered row this cycle
//               rd_valid, rd_row- offered row and its validity
// Revision    : 1.0 - initial release
// ============================================================================
module ifmap_row_buf
    import ifmap_pkg::*;
(
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic wr_en,
    input  wire word_t wr_word,
    input  wire logic pop,
    output logic      rd_valid,
    output row_t      rd_row
);

    localparam int IDX_W = (WPR > 1) ? $clog2(WPR) : 1;

    word_t            data [2][WPR];
    logic [1:0]       full;
    logic             fill;
    logic             drain;
    logic [IDX_W-1:0] widx;

    logic wr_last;
    logic bypass;

    assign wr_last  = (widx == IDX_W'(WPR - 1));
    // The drain buffer is the one completing right now: its last word is
    // still on the write port, so hand it over without waiting a cycle.
    assign bypass   = wr_en && wr_last && (fill == drain) && !full[drain];
    assign rd_valid = full[drain] || bypass;

    generate
        for (genvar k = 0; k < WPR; k++) begin : g_word
            if (k == WPR - 1) begin : g_last
                assign rd_row[k*SRAM_DW +: SRAM_DW] = full[drain] ? data[drain][k] : wr_word;
            end else begin : g_body
                assign rd_row[k*SRAM_DW +: SRAM_DW] = data[drain][k];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full  <= 2'b00;
            fill  <= 1'b0;
            drain <= 1'b0;
            widx  <= '0;
        end else begin
            if (wr_en) begin
                if (wr_last) begin
                    widx       <= '0;
                    fill       <= ~fill;
                    full[fill] <= 1'b1;
                end else begin
                    widx <= widx + IDX_W'(1);
                end
            end
            // Placed after the set so a forwarded row never leaves its
            // buffer marked full.
            if (pop) begin
                full[drain] <= 1'b0;
                drain       <= ~drain;
            end
        end
    end

    // Row storage needs no reset: only the full flags give it meaning.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data[fill][widx] <= wr_word;
        end
    end

endmodule : ifmap_row_buf
`default_nettype wire

// File: rtl/ifmap_row_loader.sv
`default_nettype none
// ============================================================================
// Module      : ifmap_row_loader
// Description : Fetches ifmap bytes from the global-buffer SRAM as 32-bit
//               words, assembles COL_NUM-byte rows in a ping-pong buffer and
//               issues one row per ifmap_en pulse to the vertical ifmap buffer.
//               Issue is held while stall is high.
// Ports       : clk, reset (async, active low)
//               start, base_addr, num_rows - launch command (latched on start)
//               stall                      - hold row issue
//               busy, done                 - status
//               bus (master)               - SRAM read port and row output
// Revision    : 1.0 - initial release
// ============================================================================
module ifmap_row_loader
    import ifmap_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              start,
    input  wire logic [ADDR_W-1:0] base_addr,
    input  wire logic [15:0]       num_rows,
    input  wire logic              stall,
    output logic                   busy,
    output logic                   done,
    ifmap_row_loader_if.master     bus
);

    localparam int RD_W = 16 + $clog2(WPR);         // holds num_rows*WPR
    localparam int CR_W = $clog2(2 * WPR + 1);      // holds 0..2*WPR

    state_t            state;
    logic [15:0]       rows_q;
    logic [15:0]       issued;
    logic [RD_W-1:0]   reads_left;
    logic [CR_W-1:0]   reserved;    // words requested but not yet issued as rows
    logic [ADDR_W-1:0] next_addr;
    logic              rvalid;      // SRAM data valid on sram_rdata this cycle

    logic rd_valid;
    row_t rd_row;
    logic pop;
    logic want_read;

    ifmap_row_buf u_row_buf (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (rvalid),
        .wr_word  (bus.sram_rdata),
        .pop      (pop),
        .rd_valid (rd_valid),
        .rd_row   (rd_row)
    );

    assign pop = (state == RUN) && rd_valid && !stall;

    // Space for two rows is reserved against requested words, so a read is
    // only launched when its data is guaranteed a slot in the ping-pong
    // pair. The count is registered, so a freed buffer re-enables reads one
    // cycle after the issue that freed it.
    assign want_read = (state == RUN) && (reads_left != '0) && (reserved < CR_W'(2 * WPR));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            rows_q        <= '0;
            issued        <= '0;
            reads_left    <= '0;
            reserved      <= '0;
            next_addr     <= '0;
            rvalid        <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.sram_ren  <= 1'b0;
            bus.sram_addr <= '0;
            bus.ifmap_out <= '0;
            bus.ifmap_en  <= 1'b0;
        end else begin
            rvalid       <= bus.sram_ren;
            bus.sram_ren <= 1'b0;
            bus.ifmap_en <= 1'b0;
            done         <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        busy   <= 1'b1;
                        rows_q <= num_rows;
                        issued <= '0;
                        if (num_rows == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            // First read goes out with the launch.
                            state         <= RUN;
                            bus.sram_ren  <= 1'b1;
                            bus.sram_addr <= base_addr;
                            next_addr     <= base_addr + ADDR_W'(1);
                            reads_left    <= RD_W'(num_rows) * RD_W'(WPR) - RD_W'(1);
                            reserved      <= CR_W'(1);
                        end
                    end
                end

                RUN: begin
                    if (want_read) begin
                        bus.sram_ren  <= 1'b1;
                        bus.sram_addr <= next_addr;
                        next_addr     <= next_addr + ADDR_W'(1);
                        reads_left    <= reads_left - RD_W'(1);
                    end
                    reserved <= reserved + CR_W'(want_read) - (pop ? CR_W'(WPR) : '0);
                    if (pop) begin
                        bus.ifmap_out <= rd_row;
                        bus.ifmap_en  <= 1'b1;
                        issued        <= issued + 16'd1;
                    end
                    // Leave once the final row's ifmap_en cycle has passed.
                    if (issued == rows_q) begin
                        state <= FIN;
                        done  <= 1'b1;
                    end
                end

                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule : ifmap_row_loader
`default_nettype wire

// File: tb/tb_ifmap_row_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifmap_row_loader
// Description : Self-checking bench for ifmap_row_loader. A behavioural SRAM
//               answers reads. Each operation is compared cycle by cycle
//               against a count-based reference model, and directed vectors
//               also carry hand-derived event cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifmap_row_loader;
    import ifmap_pkg::*;

    localparam int LIMIT = 2000;

    typedef struct {
        logic [15:0] base;
        int          n;
        int          st_lo;      // stall sampled high at edges st_lo..st_hi
        int          st_hi;
        bit          rnd;        // random per-cycle stall instead of a window
        int          restart;    // edge at which a stray start is applied (-1 none)
        int          mode;       // SRAM content pattern
        int          x_first;    // expected first ifmap_en cycle (0 = none)
        int          x_last;
        int          x_done;
        int          x_reads;
        int          x_nen;
    } vec_t;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [15:0]       num_rows;
    logic              stall;
    logic              busy;
    logic              done;
    int                mem_mode;
    int                tests;
    int                fails;

    ifmap_row_loader_if bus_if ();

    ifmap_row_loader dut (
        .clk       (clk),
        .reset     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .bus       (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic word_t mem_fn(input logic [15:0] a);
        if (mem_mode == 0) return {4{a[7:0]}};
        return (32'(a) * 32'h9E37_79B9) ^ 32'hA5C3_0F1E;
    endfunction

    // Behavioural SRAM: data is on sram_rdata the cycle after sram_ren.
    always @(posedge clk) begin
        if (bus_if.sram_ren) bus_if.sram_rdata <= mem_fn(bus_if.sram_addr);
    end

    function automatic row_t row_fn(input logic [15:0] base, input int r);
        row_t row;
        logic [15:0] a;
        for (int k = 0; k < WPR; k++) begin
            a = base + 16'(r * WPR + k);
            row[k*SRAM_DW +: SRAM_DW] = mem_fn(a);
        end
        return row;
    endfunction

    task automatic chk(input string nm, input int cy, input row_t got, input row_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cy, got, exp);
        end
    endtask

    function automatic bit stall_at(input vec_t v, input int e);
        if (v.rnd) return ($urandom_range(0, 99) < 30);
        return (e >= v.st_lo) && (e <= v.st_hi);
    endfunction

    // One operation: start is sampled at edge 0; cycle e+1 is observed after
    // edge e. The model tracks only counts: reads launched, words returned,
    // rows issued.
    task automatic run_op(input vec_t v, input bit summ);
        int   reads, iss, phase, ret, nread_obs, nen_obs, first_en, last_en, done_c;
        bit   stall_cur, x_en, x_ren, x_done, x_busy, fin, en_now;
        logic [15:0] x_addr;
        row_t x_row;
        int   hist [LIMIT];
        reads = 0; iss = 0; phase = 0; nread_obs = 0; nen_obs = 0;
        first_en = 0; last_en = 0; done_c = 0; fin = 0;
        x_addr = '0; x_row = '0;
        mem_mode = v.mode;
        @(negedge clk);
        start     = 1'b1;
        base_addr = v.base;
        num_rows  = 16'(v.n);
        stall_cur = stall_at(v, 0);
        stall     = stall_cur;
        for (int e = 0; e < LIMIT && !fin; e++) begin
            @(posedge clk);
            x_en = 0; x_ren = 0; x_done = 0; x_busy = 0;
            if (e == 0) begin
                x_busy = 1;
                if (v.n == 0) begin
                    x_done = 1; phase = 2;
                end else begin
                    x_ren = 1; x_addr = v.base; reads = 1; phase = 1;
                end
            end else if (phase == 1) begin
                x_busy = 1;
                if (iss == v.n) begin
                    x_done = 1; phase = 2;
                end else begin
                    ret    = (e >= 2) ? hist[e-2] : 0;
                    en_now = !stall_cur && (ret >= (iss + 1) * WPR);
                    if (en_now) x_row = row_fn(v.base, iss);
                    x_en = en_now;
                    if (reads < v.n * WPR && reads - iss * WPR < 2 * WPR) begin
                        x_ren = 1; x_addr = v.base + 16'(reads); reads++;
                    end
                    if (en_now) iss++;
                end
            end else if (phase == 2) begin
                phase = 3;
            end
            hist[e] = reads;
            #1;
            start     = (e + 1 == v.restart);
            base_addr = ~v.base;
            num_rows  = 16'(v.n + 3);
            stall_cur = stall_at(v, e + 1);
            stall     = stall_cur;
            @(negedge clk);
            chk("sram_ren", e + 1, row_t'(bus_if.sram_ren), row_t'(x_ren));
            if (x_ren) chk("sram_addr", e + 1, row_t'(bus_if.sram_addr), row_t'(x_addr));
            chk("ifmap_en", e + 1, row_t'(bus_if.ifmap_en), row_t'(x_en));
            if (x_en) chk("ifmap_out", e + 1, bus_if.ifmap_out, x_row);
            chk("done", e + 1, row_t'(done), row_t'(x_done));
            chk("busy", e + 1, row_t'(busy), row_t'(x_busy));
            if (bus_if.sram_ren) nread_obs++;
            if (bus_if.ifmap_en) begin
                nen_obs++;
                if (first_en == 0) first_en = e + 1;
                last_en = e + 1;
            end
            if (done && done_c == 0) done_c = e + 1;
            if (phase == 3) fin = 1;
        end
        if (!fin) chk("timeout", LIMIT, row_t'(0), row_t'(1));
        if (summ) begin
            chk("first_en_cycle", 0, row_t'(first_en),  row_t'(v.x_first));
            chk("last_en_cycle",  0, row_t'(last_en),   row_t'(v.x_last));
            chk("done_cycle",     0, row_t'(done_c),    row_t'(v.x_done));
            chk("read_count",     0, row_t'(nread_obs), row_t'(v.x_reads));
            chk("row_count",      0, row_t'(nen_obs),   row_t'(v.x_nen));
        end else begin
            chk("read_count", 0, row_t'(nread_obs), row_t'(v.n * WPR));
            chk("row_count",  0, row_t'(nen_obs),   row_t'(v.n));
        end
        start = 1'b0;
        stall = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_sram_ren"},  0, row_t'(bus_if.sram_ren),  '0);
        chk({tag, "_sram_addr"}, 0, row_t'(bus_if.sram_addr), '0);
        chk({tag, "_ifmap_out"}, 0, bus_if.ifmap_out,         '0);
        chk({tag, "_ifmap_en"},  0, row_t'(bus_if.ifmap_en),  '0);
        chk({tag, "_busy"},      0, row_t'(busy),             '0);
        chk({tag, "_done"},      0, row_t'(done),             '0);
    endtask

    initial begin
        vec_t vecs [7];
        vec_t rv;
        tests = 0; fails = 0; mem_mode = 0;
        rst_n = 1'b0; start = 1'b0; base_addr = '0; num_rows = '0; stall = 1'b0;
        bus_if.sram_rdata = '0;

        //             base     n  st_lo st_hi rnd restart mode first last done reads nen
        vecs[0] = '{16'h0010, 1,  1,    0,   0,  -1,     0,   10,   10,  11,   8,   1}; // single row
        vecs[1] = '{16'h0200, 4,  1,    0,   0,  -1,     0,   10,   34,  35,  32,   4}; // stream
        vecs[2] = '{16'h0300, 4,  5,   39,   0,  -1,     0,   41,   59,  60,  32,   4}; // backpressure
        vecs[3] = '{16'h0400, 0,  1,    0,   0,  -1,     0,    0,    0,   1,   0,   0}; // zero rows
        vecs[4] = '{16'h0500, 2,  1,    0,   0,   5,     0,   10,   18,  19,  16,   2}; // start while busy
        vecs[5] = '{16'hFFFC, 1,  1,    0,   0,  -1,     1,   10,   10,  11,   8,   1}; // address wrap
        vecs[6] = '{16'h0600, 3, 12,   20,   0,  -1,     1,   10,   26,  27,  24,   3}; // mid-run stall

        repeat (2) @(negedge clk);
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_op(vecs[i], 1'b1);

        // Abort mid-run: reset must clear outputs at once and leave the block
        // ready for a fresh start.
        mem_mode = 0;
        @(negedge clk);
        start = 1'b1; base_addr = 16'h0100; num_rows = 16'd4;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        chk("pre_abort_busy", 0, row_t'(busy), row_t'(1));
        chk("pre_abort_ren",  0, row_t'(bus_if.sram_ren), row_t'(1));
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk_all_zero("abort");
        #2 rst_n = 1'b1;
        run_op(vecs[0], 1'b1);

        for (int i = 0; i < 8; i++) begin
            rv = '{16'($urandom), int'($urandom_range(1, 5)), 1, 0, 1, -1, 1, 0, 0, 0, 0, 0};
            run_op(rv, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_ifmap_row_loader
`default_nettype wire
